// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: rotates the column drive, snapshots every row/column crossing once per frame,
// and debounces whole frames into a single key code with a one-cycle valid pulse per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_held
);
    localparam int         DIV_W  = $clog2(SCAN_DIV);
    localparam int         CNT_W  = $clog2(DEBOUNCE_N + 1);
    localparam logic [3:0] NO_KEY = 4'hF;

    typedef enum logic [2:0] {IDLE, DEB, PRESSED, REL, LOCK} state_t;

    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [11:0]      snap;
    logic             tick, frame_close;
    logic [11:0]      frame;
    logic [3:0]       n_set;
    logic [3:0]       frame_code;
    logic             frame_empty, frame_single;

    state_t           state, state_n;
    logic [3:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             cnt_hit;
    logic [3:0]       data_n;
    logic             valid_n, held_n;

    // Bit index is col*4 + row; rows 0..2 are the digit grid, row 3 holds '*', '0', '#'.
    function automatic logic [3:0] code_of(input logic [3:0] bit_idx);
        logic [1:0] c;
        logic [1:0] r;
        c = bit_idx[3:2];
        r = bit_idx[1:0];
        if (r != 2'd3) return 4'(int'(r) * 3 + int'(c) + 1);
        case (c)
            2'd0:    return 4'd10;
            2'd1:    return 4'd0;
            default: return 4'd11;
        endcase
    endfunction

    assign key_col     = 3'b001 << col_idx;
    assign tick        = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_close = tick && (col_idx == 2'd2);
    // The column-2 rows are only being written this edge, so the frame is assembled from the live sample.
    assign frame       = {row_sync, snap[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= '0;
            row_sync <= '0;
            div_cnt  <= '0;
            col_idx  <= '0;
            snap     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            row_meta <= key_row;
            row_sync <= row_meta;
            if (tick) begin
                div_cnt                   <= '0;
                snap[{col_idx, 2'b00} +: 4] <= row_sync;
                col_idx                   <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        n_set      = '0;
        frame_code = NO_KEY;
        for (int i = 0; i < 12; i++) begin
            if (frame[i]) begin
                n_set      = n_set + 4'd1;
                frame_code = code_of(4'(i));
            end
        end
    end

    assign frame_empty  = (n_set == 4'd0);
    assign frame_single = (n_set == 4'd1);
    assign cnt_inc      = (int'(cnt) >= DEBOUNCE_N) ? cnt : cnt + 1'b1;
    assign cnt_hit      = (int'(cnt) + 1 >= DEBOUNCE_N);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        data_n  = key_data;
        valid_n = 1'b0;
        held_n  = key_held;
        if (frame_close) begin
            case (state)
                IDLE: if (frame_single) begin
                    if (DEBOUNCE_N == 1) begin
                        data_n  = frame_code;
                        valid_n = 1'b1;
                        held_n  = 1'b1;
                        state_n = PRESSED;
                    end else begin
                        cand_n  = frame_code;
                        cnt_n   = CNT_W'(1);
                        state_n = DEB;
                    end
                end
                DEB: begin
                    if (frame_single && frame_code == cand) begin
                        if (cnt_hit) begin
                            data_n  = cand;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            state_n = PRESSED;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if (frame_single) begin
                        cand_n = frame_code;
                        cnt_n  = CNT_W'(1);
                    end else if (frame_empty) begin
                        state_n = IDLE;
                    end else begin
                        state_n = LOCK;
                    end
                end
                PRESSED: if (frame_empty) begin
                    if (DEBOUNCE_N == 1) begin
                        data_n  = NO_KEY;
                        held_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = CNT_W'(1);
                        state_n = REL;
                    end
                end
                REL: begin
                    if (!frame_empty) begin
                        state_n = PRESSED;
                    end else if (cnt_hit) begin
                        data_n  = NO_KEY;
                        held_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                LOCK: if (frame_empty) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cand      <= NO_KEY;
            cnt       <= '0;
            key_data  <= NO_KEY;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_data  <= data_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-level keypad model drives the rows, and a frame-level press/release
// model predicts the outputs, which are compared every cycle alongside hand-computed expectations.
module tb_keypad_scanner;
    localparam int DIV   = 4;
    localparam int DEB_N = 2;
    localparam int FRAME = 3 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [3:0]  key_data;
    logic        key_valid;
    logic        key_held;

    logic [11:0] pressed = '0;   // bit k set = key with code k physically pressed
    logic        armed = 1'b0;
    int          cyc = 0;
    int          dut_pulses = 0;
    int          valid_cyc = -1;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int         n;
        logic [3:0] data;
        logic       valid;
        logic       held;
        logic       locked;
        int         run_len;
        int         run_code;
        int         rel_run;
    } model_t;

    model_t     m;
    logic [2:0] exp_col;

    keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_N(DEB_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_data (key_data),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    function automatic int key_r(input int k);
        if (k >= 1 && k <= 9) return (k - 1) / 3;
        return 3;
    endfunction

    function automatic int key_c(input int k);
        if (k >= 1 && k <= 9) return (k - 1) % 3;
        if (k == 10) return 0;
        if (k == 0) return 1;
        return 2;
    endfunction

    function automatic logic [11:0] key(input int k);
        return 12'(1) << k;
    endfunction

    // Physical keypad: a pressed key connects its row to its column while that column is driven.
    always_comb begin
        key_row = '0;
        for (int k = 0; k < 12; k++)
            if (pressed[k] && key_col[key_c(k)] === 1'b1) key_row[key_r(k)] = 1'b1;
    end

    // Frame-level behaviour: a press is a run of DEB_N identical single-key frames, a release a run
    // of DEB_N empty frames; a multi-key frame interrupting a run locks out until an empty frame.
    function automatic model_t model_step(input model_t s, input logic [11:0] keys);
        model_t t;
        int     ones;
        int     code;
        t       = s;
        t.n     = s.n + 1;
        t.valid = 1'b0;
        if (t.n % FRAME == 0) begin
            ones = $countones(keys);
            code = -1;
            for (int k = 0; k < 12; k++) if (keys[k]) code = k;
            if (s.locked) begin
                if (ones == 0) t.locked = 1'b0;
            end else if (!s.held) begin
                if (ones == 1) begin
                    t.run_len  = (s.run_len > 0 && code == s.run_code) ? s.run_len + 1 : 1;
                    t.run_code = code;
                    if (t.run_len == DEB_N) begin
                        t.held    = 1'b1;
                        t.data    = 4'(code);
                        t.valid   = 1'b1;
                        t.run_len = 0;
                        t.rel_run = 0;
                    end
                end else begin
                    if (ones > 1 && s.run_len > 0) t.locked = 1'b1;
                    t.run_len = 0;
                end
            end else if (ones == 0) begin
                t.rel_run = s.rel_run + 1;
                if (t.rel_run == DEB_N) begin
                    t.held    = 1'b0;
                    t.data    = 4'hF;
                    t.rel_run = 0;
                end
            end else begin
                t.rel_run = 0;
            end
        end
        return t;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{n: 0, data: 4'hF, valid: 1'b0, held: 1'b0, locked: 1'b0,
                        run_len: 0, run_code: 0, rel_run: 0};
        else      m <= model_step(m, pressed);
    end

    always_comb exp_col = 3'(3'b001 << ((m.n / DIV) % 3));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("key_col",   32'(key_col),   32'(exp_col));
            check("key_data",  32'(key_data),  32'(m.data));
            check("key_valid", 32'(key_valid), 32'(m.valid));
            check("key_held",  32'(key_held),  32'(m.held));
        end
    end

    always @(negedge clk) begin
        if (armed && key_valid === 1'b1) begin
            dut_pulses <= dut_pulses + 1;
            valid_cyc  <= cyc;
        end
    end

    task automatic frames(input logic [11:0] set, input int k);
        pressed = set;
        repeat (FRAME * k) @(negedge clk);
    endtask

    initial begin
        int p0;
        int s0;
        #2 rst = 1'b0;
        #1 armed = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle scan: no pulses, columns rotate every DIV cycles.
        frames('0, 5);
        #1;
        check("idle_pulses", 32'(dut_pulses), 32'd0);
        check("idle_data", 32'(key_data), 32'hF);
        check("idle_col_frame_start", 32'(key_col), 32'b001);
        repeat (DIV) @(negedge clk);
        #1 check("idle_col_second", 32'(key_col), 32'b010);
        repeat (2 * DIV) @(negedge clk);

        // Clean press of '5', then release.
        p0 = dut_pulses;
        s0 = cyc;
        frames(key(5), 4);
        #1;
        check("k5_pulses", 32'(dut_pulses - p0), 32'd1);
        check("k5_latency", 32'(valid_cyc - s0), 32'd24);
        check("k5_data", 32'(key_data), 32'd5);
        check("k5_held", 32'(key_held), 32'd1);
        frames('0, 2);
        #1;
        check("k5_rel_held", 32'(key_held), 32'd0);
        check("k5_rel_data", 32'(key_data), 32'hF);

        // Bouncing '#': present 1, absent 1, present 3.
        p0 = dut_pulses;
        frames(key(11), 1);
        frames('0, 1);
        s0 = cyc;
        frames(key(11), 3);
        #1;
        check("hash_pulses", 32'(dut_pulses - p0), 32'd1);
        check("hash_latency", 32'(valid_cyc - s0), 32'd24);
        check("hash_data", 32'(key_data), 32'd11);
        frames('0, 2);

        // '1' lands first, then '9' joins: lock-out until an empty frame.
        p0 = dut_pulses;
        frames(key(1), 1);
        frames(key(1) | key(9), 5);
        frames(key(1), 3);
        #1 check("lock_pulses", 32'(dut_pulses - p0), 32'd0);
        frames('0, 1);
        frames(key(1), 2);
        #1;
        check("unlock_pulses", 32'(dut_pulses - p0), 32'd1);
        check("unlock_data", 32'(key_data), 32'd1);
        frames('0, 2);

        // Reset in the middle of debouncing '0'.
        p0 = dut_pulses;
        frames(key(0), 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_col", 32'(key_col), 32'b001);
        check("rst_data", 32'(key_data), 32'hF);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        s0 = cyc;
        frames(key(0), 2);
        #1;
        check("rst_k0_pulses", 32'(dut_pulses - p0), 32'd1);
        check("rst_k0_latency", 32'(valid_cyc - s0), 32'd24);
        check("rst_k0_data", 32'(key_data), 32'd0);
        frames('0, 2);

        // '7' drops for one frame while pressed: no repeat pulse, stays held.
        p0 = dut_pulses;
        frames(key(7), 2);
        frames('0, 1);
        frames(key(7), 2);
        #1;
        check("k7_pulses", 32'(dut_pulses - p0), 32'd1);
        check("k7_held", 32'(key_held), 32'd1);
        check("k7_data", 32'(key_data), 32'd7);
        frames('0, 2);
        #1 check("k7_rel_held", 32'(key_held), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
